// File: rtl/cr_xp10_comp_sde_pack_pkg.sv
// Shared types and constants for the XP10 compressor symbol packer.
// Includes the helper that masks and merges code/extra bits into one field.
package cr_xp10_compPKG;

    localparam int MAX_CODE_BITS  = 27;
    localparam int MAX_EXTRA_BITS = 16;
    localparam int SDE_SYM_W      = MAX_CODE_BITS + MAX_EXTRA_BITS;
    localparam int SDE_OUT_W      = 64;
    localparam int SDE_ACC_W      = 128;
    localparam int SDE_READY_MAX  = 84;

    typedef struct packed {
        logic [MAX_CODE_BITS-1:0]  code;
        logic [4:0]                code_len;
        logic [MAX_EXTRA_BITS-1:0] extra;
        logic [4:0]                extra_len;
        logic                      eof;
    } sde_sym_t;

    typedef enum logic {
        SDE_RUN,
        SDE_FLUSH
    } sde_state_e;

    // Code occupies the low positions; extra follows directly after code_len.
    function automatic logic [SDE_SYM_W-1:0] sde_merge(input sde_sym_t s);
        logic [MAX_CODE_BITS:0]    code_mask;
        logic [MAX_EXTRA_BITS:0]   extra_mask;
        logic [SDE_SYM_W-1:0]      code_ext;
        logic [SDE_SYM_W-1:0]      extra_ext;
        code_mask  = ((MAX_CODE_BITS+1)'(1) << s.code_len) - (MAX_CODE_BITS+1)'(1);
        extra_mask = ((MAX_EXTRA_BITS+1)'(1) << s.extra_len) - (MAX_EXTRA_BITS+1)'(1);
        code_ext   = {{MAX_EXTRA_BITS{1'b0}}, s.code & code_mask[MAX_CODE_BITS-1:0]};
        extra_ext  = {{MAX_CODE_BITS{1'b0}}, s.extra & extra_mask[MAX_EXTRA_BITS-1:0]};
        return code_ext | (extra_ext << s.code_len);
    endfunction

endpackage

// File: rtl/cr_xp10_comp_sde_pack_acc.sv
// 128-bit LSB-first bit accumulator with push/pop/clear controls.
// A pop in the same cycle as a push is applied first, so the insert lands at fill-64.
module cr_xp10_comp_sde_pack_acc
    import cr_xp10_compPKG::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic                 clear_i,
    input  logic [SDE_SYM_W-1:0] bits_i,
    input  logic [5:0]           len_i,
    output logic [SDE_OUT_W-1:0] word_o,
    output logic [7:0]           fill_o
);

    logic [SDE_ACC_W-1:0] acc_q, acc_d, acc_base;
    logic [7:0]           fill_q, fill_d, fill_base;

    always_comb begin
        acc_base  = pop_i ? (acc_q >> SDE_OUT_W) : acc_q;
        fill_base = pop_i ? (fill_q - 8'd64) : fill_q;
        acc_d     = acc_base;
        fill_d    = fill_base;
        if (clear_i) begin
            acc_d  = '0;
            fill_d = '0;
        end else if (push_i) begin
            acc_d  = acc_base | ({{(SDE_ACC_W-SDE_SYM_W){1'b0}}, bits_i} << fill_base);
            fill_d = fill_base + {2'b00, len_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            fill_q <= '0;
        end else begin
            acc_q  <= acc_d;
            fill_q <= fill_d;
        end
    end

    assign word_o = acc_q[SDE_OUT_W-1:0];
    assign fill_o = fill_q;

endmodule

// File: rtl/cr_xp10_comp_sde_pack.sv
// XP10 compressor symbol packer: packs code+extra bits LSB-first into 64-bit
// words and flushes a final partial word carrying bit and byte counts at eof.
module cr_xp10_comp_sde_pack
    import cr_xp10_compPKG::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enc_sde_valid,
    input  logic [MAX_CODE_BITS-1:0]  enc_sde_code,
    input  logic [4:0]                enc_sde_code_len,
    input  logic [MAX_EXTRA_BITS-1:0] enc_sde_extra,
    input  logic [4:0]                enc_sde_extra_len,
    input  logic                      enc_sde_eof,
    output logic                      sde_enc_ready,
    output logic                      sde_out_valid,
    output logic [SDE_OUT_W-1:0]      sde_out_data,
    output logic [6:0]                sde_out_numbits,
    output logic                      sde_out_last,
    output logic [27:0]               sde_out_frame_bytes,
    input  logic                      out_sde_ready
);

    sde_state_e           state_q, state_d;
    logic                 running_q;
    logic [30:0]          frame_bits_q, frame_bits_d;
    logic [7:0]           fill;
    logic [SDE_OUT_W-1:0] word;
    sde_sym_t             sym;
    logic [5:0]           sym_len;
    logic                 push, pop, clear, full;
    logic [31:0]          bytes_full;

    assign sym = '{code: enc_sde_code, code_len: enc_sde_code_len,
                   extra: enc_sde_extra, extra_len: enc_sde_extra_len,
                   eof: enc_sde_eof};
    assign sym_len = {1'b0, enc_sde_code_len} + {1'b0, enc_sde_extra_len};

    // running_q keeps ready low while reset is held even though fill is 0.
    assign full          = (fill >= 8'd64);
    assign sde_enc_ready = running_q && (state_q == SDE_RUN) && (fill <= SDE_READY_MAX[7:0]);
    assign sde_out_valid = full || (state_q == SDE_FLUSH);
    assign sde_out_last  = (state_q == SDE_FLUSH) && !full;
    assign push          = enc_sde_valid && sde_enc_ready;
    assign pop           = sde_out_valid && out_sde_ready;
    assign clear         = pop && sde_out_last;

    cr_xp10_comp_sde_pack_acc u_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (clear),
        .bits_i  (sde_merge(sym)),
        .len_i   (sym_len),
        .word_o  (word),
        .fill_o  (fill)
    );

    always_comb begin
        state_d      = state_q;
        frame_bits_d = frame_bits_q;
        case (state_q)
            SDE_RUN:   if (push && sym.eof) state_d = SDE_FLUSH;
            SDE_FLUSH: if (clear) state_d = SDE_RUN;
            default:   state_d = SDE_RUN;
        endcase
        if (clear) begin
            frame_bits_d = '0;
        end else if (push) begin
            frame_bits_d = frame_bits_q + {25'd0, sym_len};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SDE_RUN;
            running_q    <= 1'b0;
            frame_bits_q <= '0;
        end else begin
            state_q      <= state_d;
            running_q    <= 1'b1;
            frame_bits_q <= frame_bits_d;
        end
    end

    assign bytes_full          = ({1'b0, frame_bits_q} + 32'd7) >> 3;
    assign sde_out_data        = word;
    assign sde_out_numbits     = !sde_out_valid ? 7'd0 : (full ? 7'd64 : fill[6:0]);
    assign sde_out_frame_bytes = !sde_out_last ? 28'd0 :
                                 ((|bytes_full[31:28]) ? 28'hFFFFFFF : bytes_full[27:0]);

endmodule

// File: tb/tb_cr_xp10_comp_sde_pack.sv
// Scoreboard bench for the symbol packer: stimulus pushes expected words,
// a negedge monitor pops and compares every accepted output word.
module tb_cr_xp10_comp_sde_pack;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enc_sde_valid = 1'b0;
    logic [26:0] enc_sde_code = '0;
    logic [4:0]  enc_sde_code_len = '0;
    logic [15:0] enc_sde_extra = '0;
    logic [4:0]  enc_sde_extra_len = '0;
    logic        enc_sde_eof = 1'b0;
    logic        sde_enc_ready;
    logic        sde_out_valid;
    logic [63:0] sde_out_data;
    logic [6:0]  sde_out_numbits;
    logic        sde_out_last;
    logic [27:0] sde_out_frame_bytes;
    logic        out_sde_ready = 1'b1;

    cr_xp10_comp_sde_pack dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .enc_sde_valid       (enc_sde_valid),
        .enc_sde_code        (enc_sde_code),
        .enc_sde_code_len    (enc_sde_code_len),
        .enc_sde_extra       (enc_sde_extra),
        .enc_sde_extra_len   (enc_sde_extra_len),
        .enc_sde_eof         (enc_sde_eof),
        .sde_enc_ready       (sde_enc_ready),
        .sde_out_valid       (sde_out_valid),
        .sde_out_data        (sde_out_data),
        .sde_out_numbits     (sde_out_numbits),
        .sde_out_last        (sde_out_last),
        .sde_out_frame_bytes (sde_out_frame_bytes),
        .out_sde_ready       (out_sde_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        int          nb;
        bit          last;
        int          bytes;
    } exp_t;

    exp_t sb[$];
    bit   mq[$];
    int   mbits = 0;
    int   checks = 0;
    int   passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    endtask

    task automatic push_exp(input logic [63:0] d, input int nb, input bit last, input int bytes);
        exp_t e;
        e.data = d; e.nb = nb; e.last = last; e.bytes = bytes;
        sb.push_back(e);
    endtask

    // Bit-serial reference: append bits, emit full words, flush on eof.
    task automatic model(input logic [26:0] c, input int cl, input logic [15:0] x,
                         input int xl, input bit eof);
        logic [63:0] w;
        int n;
        for (int i = 0; i < cl; i++) mq.push_back(c[i]);
        for (int i = 0; i < xl; i++) mq.push_back(x[i]);
        mbits += cl + xl;
        while (mq.size() >= 64) begin
            w = '0;
            for (int i = 0; i < 64; i++) w[i] = mq.pop_front();
            push_exp(w, 64, 1'b0, 0);
        end
        if (eof) begin
            n = mq.size();
            w = '0;
            for (int i = 0; i < n; i++) w[i] = mq.pop_front();
            push_exp(w, n, 1'b1, (mbits + 7) / 8);
            mbits = 0;
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && sde_out_valid && out_sde_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_word", 64'(sde_out_numbits), 64'hDEAD);
            end else begin
                e = sb.pop_front();
                chk("word_data", sde_out_data, e.data);
                chk("word_numbits", 64'(sde_out_numbits), 64'(e.nb));
                chk("word_last", 64'(sde_out_last), 64'(e.last));
                if (e.last) chk("frame_bytes", 64'(sde_out_frame_bytes), 64'(e.bytes));
            end
        end
    end

    // Caller is at posedge+1; returns at posedge+1 just after acceptance, valid left high.
    task automatic send(input logic [26:0] c, input logic [4:0] cl, input logic [15:0] x,
                        input logic [4:0] xl, input bit eof, input bit use_model);
        bit r;
        enc_sde_valid = 1'b1;
        enc_sde_code = c; enc_sde_code_len = cl;
        enc_sde_extra = x; enc_sde_extra_len = xl;
        enc_sde_eof = eof;
        if (use_model) model(c, int'(cl), x, int'(xl), eof);
        r = 1'b0;
        for (int n = 0; n < 200 && !r; n++) begin
            @(negedge clk);
            r = sde_enc_ready;
            @(posedge clk);
            #1;
        end
        if (!r) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle();
        enc_sde_valid = 1'b0;
        enc_sde_eof = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && sb.size() > 0; n++) begin
            @(posedge clk);
            #1;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        @(negedge clk);
        chk({tag, "_ready"}, 64'(sde_enc_ready), 64'd0);
        chk({tag, "_valid"}, 64'(sde_out_valid), 64'd0);
        chk({tag, "_data"}, sde_out_data, 64'd0);
        chk({tag, "_numbits"}, 64'(sde_out_numbits), 64'd0);
        chk({tag, "_last"}, 64'(sde_out_last), 64'd0);
        chk({tag, "_bytes"}, 64'(sde_out_frame_bytes), 64'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", 64'(sde_enc_ready), 64'd1);

        // Single frame: 101 then 11 -> 0b11101
        push_exp(64'h1D, 5, 1'b1, 1);
        send(27'h5, 5'd3, 16'h3, 5'd2, 1'b1, 1'b0);
        idle();
        drain();

        // Garbage above the lengths must be masked off
        push_exp(64'hF, 4, 1'b1, 1);
        send(27'h7FFFFFF, 5'd4, 16'hFFFF, 5'd0, 1'b1, 1'b0);
        idle();
        drain();

        // Back-to-back 3 x 43 bits then zero-length eof: 64, 64, 1 bits; 17 bytes
        send(27'h5A5A5A5, 5'd27, 16'hBEEF, 5'd16, 1'b0, 1'b1);
        send(27'h1234567, 5'd27, 16'hCAFE, 5'd16, 1'b0, 1'b1);
        send(27'h7654321, 5'd27, 16'h0F0F, 5'd16, 1'b0, 1'b1);
        send(27'h7FFFFFF, 5'd0, 16'hFFFF, 5'd0, 1'b1, 1'b1);
        idle();
        drain();

        // Backpressure: fill reaches 86 with the output stalled
        out_sde_ready = 1'b0;
        send(27'h2AAAAAA, 5'd27, 16'h5555, 5'd16, 1'b0, 1'b1);
        send(27'h0C0FFEE, 5'd27, 16'h9876, 5'd16, 1'b0, 1'b1);
        idle();
        @(negedge clk);
        chk("bp_ready_low", 64'(sde_enc_ready), 64'd0);
        chk("bp_valid", 64'(sde_out_valid), 64'd1);
        chk("bp_data", sde_out_data, sb[0].data);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("bp_hold_data", sde_out_data, sb[0].data);
        chk("bp_hold_numbits", 64'(sde_out_numbits), 64'd64);
        @(posedge clk); #1;
        out_sde_ready = 1'b1;
        send(27'h13, 5'd5, 16'h0, 5'd0, 1'b1, 1'b1);
        idle();
        drain();

        // Empty frame, then a fresh frame with cleared counters
        push_exp(64'h0, 0, 1'b1, 0);
        send(27'h3, 5'd0, 16'h1, 5'd0, 1'b1, 1'b0);
        idle();
        drain();
        push_exp(64'h1, 1, 1'b1, 1);
        send(27'h1, 5'd1, 16'h0, 5'd0, 1'b1, 1'b0);
        idle();
        drain();

        // Reset while flushing with fill=100 (43 + 41 + 16)
        out_sde_ready = 1'b0;
        send(27'h7FFFFFF, 5'd27, 16'hFFFF, 5'd16, 1'b0, 1'b0);
        send(27'h7FFFFFF, 5'd27, 16'hFFFF, 5'd14, 1'b0, 1'b0);
        send(27'h0, 5'd0, 16'hFFFF, 5'd16, 1'b1, 1'b0);
        idle();
        @(negedge clk);
        chk("flush_valid", 64'(sde_out_valid), 64'd1);
        chk("flush_ready_low", 64'(sde_enc_ready), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        check_all_zero("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_sde_ready = 1'b1;
        @(posedge clk); #1;
        push_exp(64'h2, 2, 1'b1, 1);
        send(27'h2, 5'd2, 16'h0, 5'd0, 1'b1, 1'b0);
        idle();
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
